mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_rr_sel.sv | 14 +
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   MEM_* : memory command encodings (also the legal request commands)
//   state_e : arbiter FSM states
//   AW_DEF/DW_DEF : default address/data widths
package mem_arb_pkg;
  localparam int AW_DEF = 9;
  localparam int DW_DEF = 16;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_e;

  function automatic logic cmd_legal(input logic [1:0] c);
    return (c == MEM_READ) || (c == MEM_WRITE);
  endfunction
endpackage

// File: rtl/mem_arb_rr_sel.sv
// Two-way round-robin picker, purely combinational.
//   req0/req1 : requests from port 0 / port 1
//   last      : port granted most recently (0 or 1)
//   pick      : one-hot winner (pick[i] = port i), zero when no request
module mem_arb_rr_sel (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] pick
);
  // On a tie the port that was not granted last wins.
  assign pick[0] = req0 & (~req1 | last);
  assign pick[1] = req1 & (~req0 | ~last);
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction-fetch port 0 and data port 1 share one
// memory. One access at a time: IDLE (grant) -> ISSUE (memory command) ->
// RESP (done/err, read data capture).
//   clk, reset          : clock, synchronous active-high reset
//   reqN/cmdN/addrN/wdataN : port N request (hold req until doneN)
//   gntN/doneN/errN     : one-cycle pulses back to port N
//   rdata               : read data, valid on a read's done cycle, then held
//   mem_cmd/addr/wdata  : memory command bus, mem_rdata returns one cycle later
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [1:0]    cmd0,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  state_e        state_q, state_d;
  logic          last_q, last_d;   // port granted most recently
  logic          win_q, win_d;     // port owning the current access
  logic [1:0]    cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    pick;

  mem_arb_rr_sel u_rr (
    .req0 (req0),
    .req1 (req1),
    .last (last_q),
    .pick (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;  // port 0 wins the first tie
      win_q   <= 1'b0;
      cmd_q   <= MEM_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    err0    = 1'b0;
    err1    = 1'b0;
    mem_cmd = MEM_NONE;
    rdata   = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (|pick) begin
          gnt0    = pick[0];
          gnt1    = pick[1];
          win_d   = pick[1];
          last_d  = pick[1];
          cmd_d   = pick[1] ? cmd1   : cmd0;
          addr_d  = pick[1] ? addr1  : addr0;
          wdata_d = pick[1] ? wdata1 : wdata0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_cmd = cmd_legal(cmd_q) ? cmd_q : MEM_NONE;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        done0 = ~win_q;
        done1 = win_q;
        err0  = ~win_q & ~cmd_legal(cmd_q);
        err1  = win_q & ~cmd_legal(cmd_q);
        // Read data is passed straight through on the done cycle and kept
        // in rdata_q for the cycles after it.
        if (cmd_q == MEM_READ) begin
          rdata_d = mem_rdata;
          rdata   = mem_rdata;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset cycle aborts whatever is in flight: no pulses, bus quiet.
    if (reset) begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      done0   = 1'b0;
      done1   = 1'b0;
      err0    = 1'b0;
      err1    = 1'b0;
      mem_cmd = MEM_NONE;
      rdata   = '0;
    end
  end

  assign mem_addr  = reset ? '0 : addr_q;
  assign mem_wdata = reset ? '0 : wdata_q;
endmodule
